// File: rtl/rx_pma_pkg.sv
// rx_pma_pkg: shared constants and types for the RX PMA deserializer.
//   RX_DATA_WIDTH      symbol width (10-bit 8b/10b code groups)
//   K28_5_RDM/RDP      K28.5 comma in both running disparities, bit a in [0]
//   PHASE_W            width of the symbol phase and fill counters
//   rx_align_state_e   word-alignment FSM states
package rx_pma_pkg;
    localparam int RX_DATA_WIDTH = 10;
    localparam logic [RX_DATA_WIDTH-1:0] K28_5_RDM = 10'h17C;
    localparam logic [RX_DATA_WIDTH-1:0] K28_5_RDP = 10'h283;
    localparam int PHASE_W = 4;

    typedef enum logic {
        HUNT    = 1'b0,
        ALIGNED = 1'b1
    } rx_align_state_e;
endpackage

// File: rtl/rx_comma_detect.sv
// rx_comma_detect: serial-in shift register with a fill counter and
// a K28.5 comparator.
//   i_clk        bit-rate clock
//   i_rst        synchronous reset, active-high
//   i_en         receiver enable; low holds the shift register and empties it
//   i_bit        serial data, bit a first
//   o_sr         current 10-bit window, oldest bit in [0]
//   o_comma_hit  window is full and equals either K28.5 disparity
module rx_comma_detect
    import rx_pma_pkg::*;
#(
    parameter int                    DATA_WIDTH = RX_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] COMMA_P    = K28_5_RDM,
    parameter logic [DATA_WIDTH-1:0] COMMA_N    = K28_5_RDP
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_bit,
    output logic [DATA_WIDTH-1:0] o_sr,
    output logic                  o_comma_hit
);
    localparam logic [PHASE_W-1:0] FILL_FULL = PHASE_W'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_sr;
    logic [PHASE_W-1:0]    r_fill;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr   <= '0;
            r_fill <= '0;
        end else if (!i_en) begin
            // Window contents are kept but no longer trusted for a match.
            r_fill <= '0;
        end else begin
            r_sr <= {i_bit, r_sr[DATA_WIDTH-1:1]};
            if (r_fill != FILL_FULL)
                r_fill <= r_fill + PHASE_W'(1);
        end
    end

    assign o_sr        = r_sr;
    assign o_comma_hit = (r_fill == FILL_FULL) && ((r_sr == COMMA_P) || (r_sr == COMMA_N));
endmodule

// File: rtl/rx_pma_deserializer.sv
// rx_pma_deserializer: serial-to-parallel RX PMA with K28.5 word alignment.
//   Bit_Rate_10     bit-rate clock, rising edge
//   Rst             synchronous reset, active-high
//   RX_In           serial data, bit a (LSB) first
//   RX_Data_Enable  receiver enable; low drops back to HUNT
//   Data_out        aligned symbol, [0] = first bit received
//   RX_Valid        one-cycle strobe per emitted symbol
//   Comma_Det       one-cycle strobe with RX_Valid when the symbol is a comma
//   RX_Locked       high while ALIGNED
// Build option: define RX_COMMA_REALIGN_EN to realign on a comma seen off
// the current symbol grid; otherwise such commas are ignored.
module rx_pma_deserializer
    import rx_pma_pkg::*;
#(
    parameter int                    DATA_WIDTH = RX_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] COMMA_P    = K28_5_RDM,
    parameter logic [DATA_WIDTH-1:0] COMMA_N    = K28_5_RDP
) (
    input  logic                  Bit_Rate_10,
    input  logic                  Rst,
    input  logic                  RX_In,
    input  logic                  RX_Data_Enable,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  RX_Valid,
    output logic                  Comma_Det,
    output logic                  RX_Locked
);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] w_sr;
    logic                  w_comma_hit;

    rx_align_state_e       r_state;
    logic [PHASE_W-1:0]    r_phase;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_comma;

    rx_comma_detect #(
        .DATA_WIDTH (DATA_WIDTH),
        .COMMA_P    (COMMA_P),
        .COMMA_N    (COMMA_N)
    ) u_comma_detect (
        .i_clk       (Bit_Rate_10),
        .i_rst       (Rst),
        .i_en        (RX_Data_Enable),
        .i_bit       (RX_In),
        .o_sr        (w_sr),
        .o_comma_hit (w_comma_hit)
    );

    always_ff @(posedge Bit_Rate_10) begin
        if (Rst) begin
            r_state <= HUNT;
            r_phase <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_comma <= 1'b0;
        end else if (!RX_Data_Enable) begin
            // Data_out is deliberately left holding the last symbol.
            r_state <= HUNT;
            r_valid <= 1'b0;
            r_comma <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_comma <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_comma_hit) begin
                        r_data  <= w_sr;
                        r_valid <= 1'b1;
                        r_comma <= 1'b1;
                        r_phase <= '0;
                        r_state <= ALIGNED;
                    end
                end
                ALIGNED: begin
                    // Phase 9 means the window holds a full symbol on the grid.
                    if (r_phase == PHASE_LAST) begin
                        r_data  <= w_sr;
                        r_valid <= 1'b1;
                        r_comma <= w_comma_hit;
                        r_phase <= '0;
                    end
`ifdef RX_COMMA_REALIGN_EN
                    else if (w_comma_hit) begin
                        r_data  <= w_sr;
                        r_valid <= 1'b1;
                        r_comma <= 1'b1;
                        r_phase <= '0;
                    end
`endif
                    else begin
                        r_phase <= r_phase + PHASE_W'(1);
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign Data_out  = r_data;
    assign RX_Valid  = r_valid;
    assign Comma_Det = r_comma;
    assign RX_Locked = (r_state == ALIGNED);
endmodule

// File: doc/rx_pma_deserializer.md
Name: rx_pma_deserializer

Overview:
- Receive-side PMA counterpart of the TX serializer. Samples the serial line one bit per Bit_Rate_10 cycle and hunts for a K28.5 comma to find the symbol boundary.
- Once aligned, emits 10-bit symbols to the RX PCS, one every 10 cycles, with a valid strobe.
- Sits between the CDR-recovered bit stream and the 8b/10b decoder.

Parameters:
- DATA_WIDTH, 10, symbol width in bits; only 10 is supported.
- COMMA_P, 10'h17C, K28.5 RD- (0011111010 in abcdefghij order, with bit a in [0]).
- COMMA_N, 10'h283, K28.5 RD+ (1100000101 in abcdefghij order).

Ports:
- Bit_Rate_10  in  1  bit-rate clock; all logic on its rising edge.
- Rst  in  1  synchronous reset, active-high.
- RX_In  in  1  serial data; the first bit of each symbol is bit a (LSB).
- RX_Data_Enable  in  1  receiver enable; low forces HUNT.
- Data_out  out  DATA_WIDTH  aligned symbol; bit [0] is the first bit received.
- RX_Valid  out  1  one-cycle pulse while Data_out holds a new symbol.
- Comma_Det  out  1  one-cycle pulse, coincident with RX_Valid, when the emitted symbol is a comma.
- RX_Locked  out  1  high while in the ALIGNED state.

Behaviour:
- Interface: one clock, Bit_Rate_10; reset Rst is synchronous and active-high.
- Reset: sr=0, fill=0, phase=0, state=HUNT, Data_out=0, RX_Valid=0, Comma_Det=0, RX_Locked=0. Reset has priority over all other events; asserting it mid-symbol discards any partial word.
- Shift register: every cycle with RX_Data_Enable=1, sr <= {RX_In, sr[9:1]}. After 10 shifts, sr[0] holds the oldest bit.
- fill: saturating 0..10 count of valid bits in sr. A comma match requires fill==10.
- comma_hit: combinational, fill==10 and (sr==COMMA_P or sr==COMMA_N).
- States: HUNT and ALIGNED.
- HUNT:
  - RX_Valid=0 every cycle without a hit.
  - On comma_hit, at the next edge: Data_out<=sr, RX_Valid<=1, Comma_Det<=1, phase<=0, state<=ALIGNED.
- ALIGNED:
  - phase increments mod 10 each cycle.
  - At an edge where phase==9: Data_out<=sr, RX_Valid<=1, Comma_Det<=comma_hit. Symbols are therefore emitted every 10 cycles.
  - At all other edges: RX_Valid<=0, Comma_Det<=0, except in the off-phase case below.
- Off-phase comma (ALIGNED, comma_hit, phase!=9): handling depends on the optional feature.
- Latency: the last bit of a symbol is on RX_In before edge N and shifts into sr at edge N. It appears on Data_out with RX_Valid after edge N+1.
- RX_Data_Enable=0:
  - sr is held; fill<=0, state<=HUNT, RX_Valid<=0, Comma_Det<=0.
  - Data_out holds its last value.
  - Re-enabling restarts the hunt; a minimum of 10 bits is needed before the first match.
- RX_Locked mirrors the state register: high in ALIGNED, low in HUNT.
- The block never leaves ALIGNED on its own; loss of sync is signalled by dropping RX_Data_Enable.

Optional Feature:
- Macro: RX_COMMA_REALIGN_EN.
- Defined: an off-phase comma in ALIGNED realigns immediately. Data_out<=sr, RX_Valid<=1, Comma_Det<=1, phase<=0; RX_Locked stays high.
- Undefined: off-phase commas are ignored and the existing boundary is kept.

Decomposition:
- Package rx_pma_pkg:
  - DATA_WIDTH and the K28.5 constants.
  - rx_align_state_e enum {HUNT, ALIGNED}.
  - Width of phase (4 bits).
- Sub-module rx_comma_detect: holds sr and fill, and produces comma_hit. The parent owns the FSM, phase and the outputs.

Test Plan:
- Rst high for 3 cycles mid-stream -> all outputs 0 on the next edge; RX_Locked=0; no RX_Valid until a new comma arrives.
- 3 random bits, then 10'h17C, then 10'h155 (D21.5) twice -> Comma_Det/RX_Valid with Data_out=17C; then RX_Valid every 10 cycles with Data_out=155; RX_Locked=1.
- Same sequence with 10'h283 -> lock; Comma_Det=1 with Data_out=283; latency is exactly 2 edges after the last comma bit is presented.
- While locked, inject 10'h17C shifted by 4 bits:
  - RX_COMMA_REALIGN_EN defined -> Comma_Det at the new phase, then symbols on the new 10-cycle grid.
  - Undefined -> no extra RX_Valid; original grid kept.
- Drop RX_Data_Enable for 5 cycles while locked -> RX_Locked=0 on the next edge, no RX_Valid, Data_out held; after re-enable, lock only after a full new comma.
- Stream of 50 symbols of 10'h000/10'h3FF with no comma -> remains in HUNT, RX_Valid never asserted.
